// File: rtl/spi_reg_bridge.sv
// Byte-level command decoder between an SPI slave and a register bus.
// Each CS frame carries one command byte, then write data bytes or a single read.
module spi_reg_bridge #(
  parameter int          ADDR_WIDTH = 4,
  parameter logic [7:0]  ERR_CODE   = 8'hEE
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  input  logic                  frame_idle,
  output logic [7:0]            tx_data,
  output logic                  tx_valid,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  output logic                  bus_we,
  output logic                  bus_re,
  input  logic [7:0]            bus_rdata,
  output logic                  cmd_error
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WRITE,
    S_RD_ISSUE,
    S_RD_CAPTURE,
    S_DISCARD
  } state_t;

  // Command address bits above the implemented range must be zero.
  localparam logic [7:0] ILLEGAL_MASK = 8'h7F & ~((8'd1 << ADDR_WIDTH) - 8'd1);

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [7:0]              count_q, count_d;
  logic                    idle_prev_q, idle_prev_d;
  logic                    armed_q, armed_d;
  logic                    end_pend_q, end_pend_d;
  logic [7:0]              tx_data_q, tx_data_d;
  logic                    tx_valid_q, tx_valid_d;
  logic [ADDR_WIDTH-1:0]   bus_addr_q, bus_addr_d;
  logic [7:0]              bus_wdata_q, bus_wdata_d;
  logic                    bus_we_q, bus_we_d;
  logic                    bus_re_q, bus_re_d;
  logic                    cmd_error_q, cmd_error_d;

  logic                    byte_ok;
  logic                    frame_end;
  logic                    cmd_illegal;
  logic [ADDR_WIDTH-1:0]   cmd_addr;

  // A byte arriving as the frame closes is dropped.
  assign byte_ok     = rx_valid & ~frame_idle;
  assign frame_end   = frame_idle & ~idle_prev_q;
  assign cmd_illegal = |(rx_data & ILLEGAL_MASK);
  assign cmd_addr    = rx_data[ADDR_WIDTH-1:0];

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    count_d     = count_q;
    idle_prev_d = frame_idle;
    // Commands are only trusted once an idle gap has been seen, so a reset
    // landing mid-frame does not misread a data byte as a command.
    armed_d     = armed_q | frame_idle;
    end_pend_d  = end_pend_q;
    tx_data_d   = tx_data_q;
    tx_valid_d  = 1'b0;
    bus_addr_d  = bus_addr_q;
    bus_wdata_d = bus_wdata_q;
    bus_we_d    = 1'b0;
    bus_re_d    = 1'b0;
    cmd_error_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        end_pend_d = 1'b0;
        if (byte_ok && armed_q) begin
          if (cmd_illegal) begin
            cmd_error_d = 1'b1;
            tx_valid_d  = 1'b1;
            tx_data_d   = ERR_CODE;
            state_d     = S_DISCARD;
          end else if (rx_data[7]) begin
            addr_d  = cmd_addr;
            count_d = 8'd0;
            state_d = S_WRITE;
          end else begin
            bus_re_d   = 1'b1;
            bus_addr_d = cmd_addr;
            state_d    = S_RD_ISSUE;
          end
        end
      end

      S_WRITE: begin
        if (frame_end) begin
          if (count_q != 8'd0) begin
            tx_valid_d = 1'b1;
            tx_data_d  = count_q;
          end
          count_d = 8'd0;
          state_d = S_IDLE;
        end else if (byte_ok) begin
          bus_we_d    = 1'b1;
          bus_addr_d  = addr_q;
          bus_wdata_d = rx_data;
          addr_d      = addr_q + ADDR_WIDTH'(1);
          count_d     = (count_q == 8'hFF) ? count_q : count_q + 8'd1;
        end
      end

      // bus_re is on the bus this cycle; read data lands next cycle.
      S_RD_ISSUE: begin
        if (frame_end) end_pend_d = 1'b1;
        state_d = S_RD_CAPTURE;
      end

      S_RD_CAPTURE: begin
        tx_valid_d = 1'b1;
        tx_data_d  = bus_rdata;
        end_pend_d = 1'b0;
        state_d    = (end_pend_q || frame_end) ? S_IDLE : S_DISCARD;
      end

      S_DISCARD: begin
        if (frame_end) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      count_q     <= 8'd0;
      idle_prev_q <= 1'b1;
      armed_q     <= 1'b0;
      end_pend_q  <= 1'b0;
      tx_data_q   <= 8'h00;
      tx_valid_q  <= 1'b0;
      bus_addr_q  <= '0;
      bus_wdata_q <= 8'h00;
      bus_we_q    <= 1'b0;
      bus_re_q    <= 1'b0;
      cmd_error_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      count_q     <= count_d;
      idle_prev_q <= idle_prev_d;
      armed_q     <= armed_d;
      end_pend_q  <= end_pend_d;
      tx_data_q   <= tx_data_d;
      tx_valid_q  <= tx_valid_d;
      bus_addr_q  <= bus_addr_d;
      bus_wdata_q <= bus_wdata_d;
      bus_we_q    <= bus_we_d;
      bus_re_q    <= bus_re_d;
      cmd_error_q <= cmd_error_d;
    end
  end

  assign tx_data   = tx_data_q;
  assign tx_valid  = tx_valid_q;
  assign bus_addr  = bus_addr_q;
  assign bus_wdata = bus_wdata_q;
  assign bus_we    = bus_we_q;
  assign bus_re    = bus_re_q;
  assign cmd_error = cmd_error_q;

endmodule

// File: tb/tb_spi_reg_bridge.sv
// Directed bench for spi_reg_bridge: expected bus/tx events are queued with
// their cycle stamps as stimulus is driven and matched as the DUT emits them.
module tb_spi_reg_bridge;

  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          frame_idle = 1'b1;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic [AW-1:0] bus_addr;
  logic [7:0]    bus_wdata;
  logic          bus_we;
  logic          bus_re;
  logic [7:0]    bus_rdata = 8'h00;
  logic          cmd_error;

  spi_reg_bridge #(.ADDR_WIDTH(AW), .ERR_CODE(8'hEE)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid),
    .frame_idle(frame_idle), .tx_data(tx_data), .tx_valid(tx_valid),
    .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_we(bus_we),
    .bus_re(bus_re), .bus_rdata(bus_rdata), .cmd_error(cmd_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int         cyc;
    logic [7:0] a;
    logic [7:0] d;
  } ev_t;

  ev_t q_we[$], q_re[$], q_tx[$], q_err[$];
  ev_t mon_e;
  int  cyc = 0;
  int  n_checks = 0;
  int  n_err = 0;
  logic [7:0] mem [1<<AW];

  always @(posedge clk) cyc <= cyc + 1;

  // Register file with one-cycle read latency; junk when no read was issued.
  always @(posedge clk) bus_rdata <= bus_re ? mem[bus_addr] : 8'hC3;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic ev_t mk(input int c, input logic [7:0] a, input logic [7:0] d);
    ev_t e;
    e.cyc = c; e.a = a; e.d = d;
    return e;
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      chk("we_re_exclusive", {31'd0, bus_we & bus_re}, 32'd0);
      if (bus_we) begin
        chk("we_expected", {31'd0, q_we.size() > 0}, 32'd1);
        if (q_we.size() > 0) begin
          mon_e = q_we.pop_front();
          chk("we_cycle", cyc, mon_e.cyc);
          chk("we_addr", {28'd0, bus_addr}, {24'd0, mon_e.a});
          chk("we_data", {24'd0, bus_wdata}, {24'd0, mon_e.d});
        end
      end
      if (bus_re) begin
        chk("re_expected", {31'd0, q_re.size() > 0}, 32'd1);
        if (q_re.size() > 0) begin
          mon_e = q_re.pop_front();
          chk("re_cycle", cyc, mon_e.cyc);
          chk("re_addr", {28'd0, bus_addr}, {24'd0, mon_e.a});
        end
      end
      if (tx_valid) begin
        chk("tx_expected", {31'd0, q_tx.size() > 0}, 32'd1);
        if (q_tx.size() > 0) begin
          mon_e = q_tx.pop_front();
          chk("tx_cycle", cyc, mon_e.cyc);
          chk("tx_data", {24'd0, tx_data}, {24'd0, mon_e.d});
        end
      end
      if (cmd_error) begin
        chk("err_expected", {31'd0, q_err.size() > 0}, 32'd1);
        if (q_err.size() > 0) begin
          mon_e = q_err.pop_front();
          chk("err_cycle", cyc, mon_e.cyc);
        end
      end
    end
  end

  // Inputs are held for the current cycle (index cyc); returns 1ns into the next.
  task automatic drive(input logic v, input logic [7:0] d, input logic idle);
    rx_valid = v; rx_data = d; frame_idle = idle;
    @(posedge clk); #1;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, 8'h00, 1'b1);
  endtask

  task automatic send_we(input logic [7:0] d, input logic [7:0] a);
    q_we.push_back(mk(cyc + 1, a, d));
    drive(1'b1, d, 1'b0);
  endtask

  task automatic end_frame(input logic resp, input logic [7:0] cnt);
    drive(1'b0, 8'h00, 1'b0);
    if (resp) q_tx.push_back(mk(cyc + 1, 8'h00, cnt));
    drive(1'b0, 8'h00, 1'b1);
    idle_cycles(3);
  endtask

  task automatic drain(input string tag);
    chk({tag, "_we_left"},  q_we.size(),  0);
    chk({tag, "_re_left"},  q_re.size(),  0);
    chk({tag, "_tx_left"},  q_tx.size(),  0);
    chk({tag, "_err_left"}, q_err.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < (1<<AW); i++) mem[i] = 8'h55 + 8'(i);

    // Reset state
    @(posedge clk); #1;
    chk("rst_tx_data",   {24'd0, tx_data},   32'h00);
    chk("rst_tx_valid",  {31'd0, tx_valid},  32'd0);
    chk("rst_bus_addr",  {28'd0, bus_addr},  32'd0);
    chk("rst_bus_wdata", {24'd0, bus_wdata}, 32'h00);
    chk("rst_bus_we",    {31'd0, bus_we},    32'd0);
    chk("rst_bus_re",    {31'd0, bus_re},    32'd0);
    chk("rst_cmd_error", {31'd0, cmd_error}, 32'd0);
    rst = 1'b0;
    idle_cycles(3);

    // Write burst at address 3
    drive(1'b1, 8'h83, 1'b0);
    send_we(8'h11, 8'd3);
    send_we(8'h22, 8'd4);
    end_frame(1'b1, 8'h02);
    drain("burst");

    // Address wrap 15 -> 0
    drive(1'b1, 8'h8F, 1'b0);
    send_we(8'hAA, 8'd15);
    send_we(8'hBB, 8'd0);
    end_frame(1'b1, 8'h02);
    drain("wrap");

    // Read of address 5, extra bytes ignored
    q_re.push_back(mk(cyc + 1, 8'd5, 8'h00));
    q_tx.push_back(mk(cyc + 3, 8'h00, 8'h5A));
    drive(1'b1, 8'h05, 1'b0);
    drive(1'b1, 8'h87, 1'b0);
    drive(1'b1, 8'h88, 1'b0);
    drive(1'b1, 8'h99, 1'b0);
    end_frame(1'b0, 8'h00);
    drain("read");

    // Illegal command, rest of frame discarded
    q_err.push_back(mk(cyc + 1, 8'h00, 8'h00));
    q_tx.push_back(mk(cyc + 1, 8'h00, 8'hEE));
    drive(1'b1, 8'h10, 1'b0);
    drive(1'b1, 8'h85, 1'b0);
    drive(1'b1, 8'h01, 1'b0);
    end_frame(1'b0, 8'h00);
    drain("illegal");

    // Empty write frame gives no response
    drive(1'b1, 8'h80, 1'b0);
    end_frame(1'b0, 8'h00);
    drain("empty");

    // Byte coinciding with frame end is dropped
    drive(1'b1, 8'h81, 1'b0);
    send_we(8'h33, 8'd1);
    q_tx.push_back(mk(cyc + 1, 8'h00, 8'h01));
    drive(1'b1, 8'h44, 1'b1);
    idle_cycles(3);
    drain("race");

    // Frame ends while a read is in flight; read still completes
    q_re.push_back(mk(cyc + 1, 8'd7, 8'h00));
    q_tx.push_back(mk(cyc + 3, 8'h00, 8'h5C));
    drive(1'b1, 8'h07, 1'b0);
    drive(1'b0, 8'h00, 1'b1);
    idle_cycles(4);
    drain("rdend");

    // Reset in the middle of a write frame
    drive(1'b1, 8'h82, 1'b0);
    send_we(8'h12, 8'd2);
    rx_valid = 1'b0;
    #5;
    rst = 1'b1;
    #1;
    chk("mid_rst_bus_we",    {31'd0, bus_we},    32'd0);
    chk("mid_rst_bus_addr",  {28'd0, bus_addr},  32'd0);
    chk("mid_rst_bus_wdata", {24'd0, bus_wdata}, 32'h00);
    chk("mid_rst_tx_data",   {24'd0, tx_data},   32'h00);
    chk("mid_rst_tx_valid",  {31'd0, tx_valid},  32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    drive(1'b1, 8'h34, 1'b0);
    drive(1'b1, 8'h56, 1'b0);
    end_frame(1'b0, 8'h00);
    drain("mid_rst");

    // Recovery with a fresh frame
    drive(1'b1, 8'h8A, 1'b0);
    send_we(8'h77, 8'd10);
    end_frame(1'b1, 8'h01);
    drain("recover");

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
